// File: rtl/instr_type.sv
// Shared instruction-side types: store kinds from the decoder, the store
// unit's fault codes and its control-FSM state encoding.
package instr_type;

    // Store width as classified by the store decoder.
    typedef enum logic [1:0] {
        sk_sb      = 2'd0,
        sk_sh      = 2'd1,
        sk_sw      = 2'd2,
        sk_invalid = 2'd3
    } store_kind_t;

    // Completion status returned to the pipeline alongside done_valid.
    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_KIND     = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } store_fault_t;

    // Store unit control states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } store_state_t;

endpackage

// File: rtl/store_lane.sv
// Combinational lane formatter: maps a store kind, byte offset and register
// value onto byte strobes and lane-replicated write data, and flags requests
// that must not reach memory.
module store_lane
    import instr_type::*;
(
    input  store_kind_t  kind,
    input  logic [1:0]   off,
    input  logic [31:0]  data,
    output logic [3:0]   wstrb,
    output logic [31:0]  wdata,
    output logic         misaligned,
    output logic         invalid
);

    // Each byte lane carries the source byte that its access width maps onto
    // it: words pass straight through, halves repeat in both halves, bytes
    // repeat in all four lanes. The strobes pick the lanes actually written.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata[8*gi +: 8] = (kind == sk_sw) ? data[8*gi +: 8]
                                : (kind == sk_sh) ? data[8*(gi%2) +: 8]
                                :                   data[7:0];
    end

    // Strobe pattern and alignment/kind checks for the current request.
    always_comb begin
        wstrb      = 4'b0000;
        misaligned = 1'b0;
        invalid    = 1'b0;
        case (kind)
            sk_sb: begin
                wstrb = 4'b0001 << off;
            end
            sk_sh: begin
                wstrb      = 4'b0011 << off;
                misaligned = off[0];
            end
            sk_sw: begin
                wstrb      = 4'b1111;
                misaligned = |off;
            end
            default: begin
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_unit.sv
// Store unit: accepts one store at a time from execute, formats it for the
// data-memory write port, waits for the memory handshake (with an optional
// watchdog) and reports completion or a fault with a one-cycle pulse.
module store_unit
    import instr_type::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  store_kind_t   req_kind,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_data,
    output logic          mem_valid,
    input  logic          mem_ready,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    output logic          done_valid,
    output store_fault_t  done_fault
);

    // A zero timeout turns the watchdog off; the last count value is only
    // meaningful when it is enabled.
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    store_state_t      state_q,      state_d;
    logic              req_ready_q,  req_ready_d;
    logic              mem_valid_q,  mem_valid_d;
    logic [31:0]       mem_addr_q,   mem_addr_d;
    logic [31:0]       mem_wdata_q,  mem_wdata_d;
    logic [3:0]        mem_wstrb_q,  mem_wstrb_d;
    logic              done_valid_q, done_valid_d;
    store_fault_t      done_fault_q, done_fault_d;
    store_fault_t      fault_q,      fault_d;
    logic [CNT_W-1:0]  cnt_q,        cnt_d;

    logic [3:0]        lane_wstrb;
    logic [31:0]       lane_wdata;
    logic              lane_misaligned;
    logic              lane_invalid;

    store_lane u_lane (
        .kind       (req_kind),
        .off        (req_addr[1:0]),
        .data       (req_data),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned),
        .invalid    (lane_invalid)
    );

    // Next-state and registered-output computation for the store FSM.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        fault_d      = fault_q;
        cnt_d        = cnt_q;
        done_valid_d = 1'b0;
        done_fault_d = FLT_NONE;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    if (lane_invalid) begin
                        state_d = ST_RESP;
                        fault_d = FLT_KIND;
                    end else if (lane_misaligned) begin
                        state_d = ST_RESP;
                        fault_d = FLT_MISALIGN;
                    end else begin
                        state_d     = ST_REQ;
                        fault_d     = FLT_NONE;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wdata_d = lane_wdata;
                        mem_wstrb_d = lane_wstrb;
                        cnt_d       = '0;
                    end
                end
            end
            ST_REQ: begin
                // A handshake on the watchdog's last cycle still counts as success.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    fault_d     = FLT_NONE;
                end else if (WDOG_EN && (cnt_q == CNT_LAST)) begin
                    mem_valid_d = 1'b0;
                    state_d     = ST_RESP;
                    fault_d     = FLT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                done_valid_d = 1'b1;
                done_fault_d = fault_q;
                req_ready_d  = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                mem_valid_d = 1'b0;
                req_ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything, aborting any store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            done_valid_q <= 1'b0;
            done_fault_q <= FLT_NONE;
            fault_q      <= FLT_NONE;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            done_valid_q <= done_valid_d;
            done_fault_q <= done_fault_d;
            fault_q      <= fault_d;
            cnt_q        <= cnt_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign done_valid = done_valid_q;
    assign done_fault = done_fault_q;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: the driver pushes expected memory writes
// and done pulses, a negedge monitor pops and compares them as they appear.
module tb_store_unit;
    import instr_type::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_exp_t;

    typedef struct {
        store_fault_t fault;
        int           cyc;
    } done_exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    store_kind_t  req_kind;
    logic [31:0]  req_addr;
    logic [31:0]  req_data;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_wstrb;
    logic         done_valid;
    store_fault_t done_fault;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mem_exp_t  mem_q[$];
    done_exp_t done_q[$];

    int mem_wait = 0;
    bit mem_hang = 1'b0;
    int wait_cnt = 0;

    int n_mem_rise = 0;
    int exp_rise   = 0;
    int run        = 0;
    int last_run   = 0;
    int last_acc   = 0;

    logic        prev_mv = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;

    store_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_kind   (req_kind),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .done_valid (done_valid),
        .done_fault (done_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: ready after mem_wait cycles of valid, or never when hung.
    initial begin
        mem_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                mem_ready = (!mem_hang && (wait_cnt >= mem_wait));
                wait_cnt++;
            end else begin
                mem_ready = 1'b0;
                wait_cnt  = 0;
            end
        end
    end

    // Monitor: compare memory transfers and done pulses against the queues.
    initial begin
        mem_exp_t  me;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (mem_valid && mem_ready) begin
                if (mem_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL mem_unexpected: write addr=0x%08h with no expected write", mem_addr);
                end else begin
                    me = mem_q.pop_front();
                    $display("mem write: addr=0x%08h wdata=0x%08h wstrb=%b", mem_addr, mem_wdata, mem_wstrb);
                    check("mem_addr", mem_addr, me.addr);
                    check("mem_wdata", mem_wdata, me.wdata);
                    check("mem_wstrb", 32'(mem_wstrb), 32'(me.wstrb));
                end
            end
            if (mem_valid && prev_mv) begin
                check("hold_addr", mem_addr, prev_addr);
                check("hold_wdata", mem_wdata, prev_wdata);
                check("hold_wstrb", 32'(mem_wstrb), 32'(prev_wstrb));
            end
            if (mem_valid && !prev_mv) n_mem_rise++;
            if (mem_valid) begin
                run++;
            end else if (run > 0) begin
                last_run = run;
                run      = 0;
            end
            if (done_valid) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL done_unexpected: pulse fault=%0d cyc=%0d with none expected", done_fault, cyc);
                end else begin
                    de = done_q.pop_front();
                    $display("done: fault=%0d cyc=%0d", done_fault, cyc);
                    check("done_fault", 32'(done_fault), 32'(de.fault));
                    check("done_cycle", cyc, de.cyc);
                end
            end
            prev_mv    = mem_valid;
            prev_addr  = mem_addr;
            prev_wdata = mem_wdata;
            prev_wstrb = mem_wstrb;
        end
    end

    // Present a request (called at a negedge), wait for acceptance, queue expectations.
    task automatic issue(input store_kind_t k, input logic [31:0] a, input logic [31:0] d,
                         input bit launch, input bit push_mem, input logic [31:0] ea,
                         input logic [31:0] ew, input logic [3:0] es,
                         input bit push_done, input store_fault_t ef, input int lat,
                         input bit hold);
        int g = 0;
        req_valid = 1'b1;
        req_kind  = k;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1 within 50 cycles", req_ready);
        end else begin
            last_acc = cyc;
            if (launch) exp_rise++;
            if (push_mem) mem_q.push_back('{addr: ea, wdata: ew, wstrb: es});
            if (push_done) done_q.push_back('{fault: ef, cyc: cyc + lat});
        end
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((done_q.size() != 0 || !req_ready) && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (g >= 40) begin
            n_cmp++; n_fail++;
            $display("FAIL drain_timeout: %0d pending done pulses, required 0", done_q.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int acc1;
        int rise0;
        rst       = 1'b0;
        req_valid = 1'b0;
        req_kind  = sk_sb;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) @(negedge clk);

        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_mem_valid", 32'(mem_valid), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 0);
        check("rst_done_valid", 32'(done_valid), 0);
        check("rst_done_fault", 32'(done_fault), 32'(FLT_NONE));

        rst = 1'b1;
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 1);

        // sb at offset 3, zero-wait memory
        mem_wait = 0;
        issue(sk_sb, 32'h0000_1003, 32'hAABB_CCDD, 1, 1, 32'h0000_1000, 32'hDDDD_DDDD, 4'b1000,
              1, FLT_NONE, 3, 0);
        wait_drain();

        // sh at offset 2, memory stalls 3 cycles
        mem_wait = 3;
        issue(sk_sh, 32'h0000_2002, 32'h0000_1234, 1, 1, 32'h0000_2000, 32'h1234_1234, 4'b1100,
              1, FLT_NONE, 6, 0);
        wait_drain();
        check("sh_valid_cycles", last_run, 4);

        // Faulting requests never reach memory
        mem_wait = 0;
        rise0 = n_mem_rise;
        issue(sk_sw, 32'h0000_0006, 32'h1111_1111, 0, 0, 0, 0, 4'b0000, 1, FLT_MISALIGN, 2, 0);
        wait_drain();
        issue(sk_sh, 32'h0000_0001, 32'h2222_2222, 0, 0, 0, 0, 4'b0000, 1, FLT_MISALIGN, 2, 0);
        wait_drain();
        issue(sk_invalid, 32'h0000_0000, 32'h3333_3333, 0, 0, 0, 0, 4'b0000, 1, FLT_KIND, 2, 0);
        wait_drain();
        check("fault_no_mem_valid", n_mem_rise, rise0);

        // Further lane patterns
        issue(sk_sb, 32'h0000_0000, 32'h1234_5678, 1, 1, 32'h0000_0000, 32'h7878_7878, 4'b0001,
              1, FLT_NONE, 3, 0);
        wait_drain();
        issue(sk_sb, 32'h0000_0001, 32'h0000_00A5, 1, 1, 32'h0000_0000, 32'hA5A5_A5A5, 4'b0010,
              1, FLT_NONE, 3, 0);
        wait_drain();
        issue(sk_sb, 32'h0000_8002, 32'h0000_00FF, 1, 1, 32'h0000_8000, 32'hFFFF_FFFF, 4'b0100,
              1, FLT_NONE, 3, 0);
        wait_drain();
        issue(sk_sh, 32'h0000_0000, 32'hDEAD_BEEF, 1, 1, 32'h0000_0000, 32'hBEEF_BEEF, 4'b0011,
              1, FLT_NONE, 3, 0);
        wait_drain();
        issue(sk_sw, 32'h0000_4004, 32'hCAFE_F00D, 1, 1, 32'h0000_4004, 32'hCAFE_F00D, 4'b1111,
              1, FLT_NONE, 3, 0);
        wait_drain();

        // Watchdog expiry with memory never ready
        mem_hang = 1'b1;
        issue(sk_sw, 32'h0000_5000, 32'h0000_0001, 1, 0, 0, 0, 4'b0000, 1, FLT_TIMEOUT, 6, 0);
        wait_drain();
        check("timeout_valid_cycles", last_run, 4);
        mem_hang = 1'b0;

        // Ready on the watchdog's last cycle wins
        mem_wait = 3;
        issue(sk_sw, 32'h0000_5004, 32'h0000_0002, 1, 1, 32'h0000_5004, 32'h0000_0002, 4'b1111,
              1, FLT_NONE, 6, 0);
        wait_drain();
        check("late_ready_valid_cycles", last_run, 4);

        // Reset during REQ: mem_valid drops at once, no done pulse
        mem_wait = 0;
        mem_hang = 1'b1;
        issue(sk_sw, 32'h0000_6000, 32'h0000_0003, 1, 0, 0, 0, 4'b0000, 0, FLT_NONE, 0, 0);
        check("pre_reset_mem_valid", 32'(mem_valid), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_mem_valid", 32'(mem_valid), 0);
        check("async_rst_req_ready", 32'(req_ready), 0);
        check("async_rst_mem_addr", mem_addr, 0);
        check("async_rst_mem_wstrb", 32'(mem_wstrb), 0);
        @(negedge clk);
        check("rst_no_done", 32'(done_valid), 0);
        rst      = 1'b1;
        mem_hang = 1'b0;
        @(negedge clk);
        check("ready_after_mid_reset", 32'(req_ready), 1);
        issue(sk_sw, 32'h0000_3000, 32'h1122_3344, 1, 1, 32'h0000_3000, 32'h1122_3344, 4'b1111,
              1, FLT_NONE, 3, 0);
        wait_drain();

        // Back-to-back with req_valid held high
        issue(sk_sb, 32'h0000_7001, 32'h0000_0055, 1, 1, 32'h0000_7000, 32'h5555_5555, 4'b0010,
              1, FLT_NONE, 3, 1);
        acc1 = last_acc;
        issue(sk_sh, 32'h0000_7002, 32'h0000_9876, 1, 1, 32'h0000_7000, 32'h9876_9876, 4'b1100,
              1, FLT_NONE, 3, 0);
        check("b2b_accept_spacing", last_acc - acc1, 3);
        wait_drain();

        repeat (4) @(negedge clk);
        check("mem_q_empty", 32'(mem_q.size()), 0);
        check("done_q_empty", 32'(done_q.size()), 0);
        check("mem_valid_launches", n_mem_rise, exp_rise);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
